id_ex_stage: RTL and testbench

//  ID->EX pipeline register of the 5-stage RV32I pipe. Captures the control bundle from control_decoder

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/id_ex_stage_if.sv | 48 ++++
 rtl/id_ex_stage_load_use_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and decode helpers for the 5-stage RV32I pipe.
//   ex_ctrl_t   : 15-bit control bundle produced by control_decoder and
//                 carried ID->EX (field order MSB first as listed).
//   OPC_*       : RV32I major opcodes.
//   ALU_*       : alu_control encodings.
//   uses_rs1()  : opcode reads rs1.
//   uses_rs2()  : opcode reads rs2.
package pipe_pkg;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       jalr;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_en;
    logic       operand_a;
    logic       operand_b;
    logic       branch;
    logic       next_sel;
    logic [3:0] alu_control;
  } ex_ctrl_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_I_ALU) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bus. Handshake: the ID side presents id_* every cycle with
// id_valid_i marking a real instruction; there is no ready wire. Back-pressure
// is the stage's separate stall_o, during which upstream must keep id_*
// unchanged so the same instruction is re-presented.
//   master : ID stage side (drives id_*, observes ex_*)
//   slave  : id_ex_stage (samples id_*, drives ex_*)
interface id_ex_if
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic            id_valid_i;
  ex_ctrl_t        id_ctrl_i;
  logic [6:0]      id_opcode_i;
  logic [2:0]      id_fun3_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic [4:0]      id_rd_i;
  logic [XLEN-1:0] id_pc_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic [XLEN-1:0] id_imm_i;

  logic            ex_valid_o;
  ex_ctrl_t        ex_ctrl_o;
  logic [2:0]      ex_fun3_o;
  logic [4:0]      ex_rs1_o;
  logic [4:0]      ex_rs2_o;
  logic [4:0]      ex_rd_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_rs1_data_o;
  logic [XLEN-1:0] ex_rs2_data_o;
  logic [XLEN-1:0] ex_imm_o;

  modport master (
    output id_valid_i, id_ctrl_i, id_opcode_i, id_fun3_i, id_rs1_i, id_rs2_i,
           id_rd_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    input  ex_valid_o, ex_ctrl_o, ex_fun3_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
           ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o
  );

  modport slave (
    input  id_valid_i, id_ctrl_i, id_opcode_i, id_fun3_i, id_rs1_i, id_rs2_i,
           id_rd_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    output ex_valid_o, ex_ctrl_o, ex_fun3_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
           ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o
  );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. x0 never creates a dependency.
//   id_valid_i, id_opcode_i, id_rs1_i, id_rs2_i : consumer in ID
//   ex_valid_i, ex_load_i, ex_rd_i              : producer in EX
//   load_use_o                                  : hazard present
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_load_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);
  logic rs1_hit;
  logic rs2_hit;

  // Register fields of opcodes that do not read them hold immediate bits,
  // so matches are qualified by the opcode's actual usage.
  assign rs1_hit = uses_rs1(id_opcode_i) && (ex_rd_i == id_rs1_i);
  assign rs2_hit = uses_rs2(id_opcode_i) && (ex_rd_i == id_rs2_i);

  assign load_use_o = id_valid_i && ex_valid_i && ex_load_i &&
                      (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use detection, bubble insertion on
// load-use or flush, global freeze and saturating stall/flush counters.
//   clk, rst_n     : clock, async active-low reset
//   hold_i         : freeze all state (a flush arriving now is remembered)
//   flush_i        : kill the instruction in ID
//   clr_cnt_i      : clear both counters (ignored under hold_i)
//   bus            : id_ex_if slave (id_* in, ex_* out)
//   stall_o        : hold PC and IF/ID this cycle
//   stall_cnt_o    : load-use bubbles inserted
//   flush_cnt_o    : flush bubbles inserted
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             clr_cnt_i,
  id_ex_if.slave           bus,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam logic [XLEN-1:0]  ZERO_X  = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load_use;
  logic flush_pend;
  logic flush_eff;

  load_use_detect u_lud (
    .id_valid_i  (bus.id_valid_i),
    .id_opcode_i (bus.id_opcode_i),
    .id_rs1_i    (bus.id_rs1_i),
    .id_rs2_i    (bus.id_rs2_i),
    .ex_valid_i  (bus.ex_valid_o),
    .ex_load_i   (bus.ex_ctrl_o.load),
    .ex_rd_i     (bus.ex_rd_o),
    .load_use_o  (load_use)
  );

  // A flush that lands during hold is kept in flush_pend and applied on the
  // first free edge; a flush always outranks the load-use stall.
  assign flush_eff = flush_i | flush_pend;
  assign stall_o   = load_use & ~flush_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend        <= 1'b0;
      bus.ex_valid_o    <= 1'b0;
      bus.ex_ctrl_o     <= '0;
      bus.ex_fun3_o     <= '0;
      bus.ex_rs1_o      <= '0;
      bus.ex_rs2_o      <= '0;
      bus.ex_rd_o       <= '0;
      bus.ex_pc_o       <= ZERO_X;
      bus.ex_rs1_data_o <= ZERO_X;
      bus.ex_rs2_data_o <= ZERO_X;
      bus.ex_imm_o      <= ZERO_X;
    end else if (hold_i) begin
      flush_pend <= flush_pend | flush_i;
    end else if (flush_eff || load_use) begin
      flush_pend        <= 1'b0;
      bus.ex_valid_o    <= 1'b0;
      bus.ex_ctrl_o     <= '0;
      bus.ex_fun3_o     <= '0;
      bus.ex_rs1_o      <= '0;
      bus.ex_rs2_o      <= '0;
      bus.ex_rd_o       <= '0;
      bus.ex_pc_o       <= ZERO_X;
      bus.ex_rs1_data_o <= ZERO_X;
      bus.ex_rs2_data_o <= ZERO_X;
      bus.ex_imm_o      <= ZERO_X;
    end else begin
      flush_pend        <= 1'b0;
      bus.ex_valid_o    <= bus.id_valid_i;
      bus.ex_ctrl_o     <= bus.id_valid_i ? bus.id_ctrl_i : '0;
      bus.ex_fun3_o     <= bus.id_fun3_i;
      bus.ex_rs1_o      <= bus.id_rs1_i;
      bus.ex_rs2_o      <= bus.id_rs2_i;
      bus.ex_rd_o       <= bus.id_rd_i;
      bus.ex_pc_o       <= bus.id_pc_i;
      bus.ex_rs1_data_o <= bus.id_rs1_data_i;
      bus.ex_rs2_data_o <= bus.id_rs2_data_i;
      bus.ex_imm_o      <= bus.id_imm_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (!hold_i) begin
      if (clr_cnt_i) begin
        stall_cnt_o <= '0;
        flush_cnt_o <= '0;
      end else if (flush_eff) begin
        if (flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + 1'b1;
      end else if (load_use) begin
        if (stall_cnt_o != CNT_MAX) stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle vector table for the main
// pipeline behaviour, then hand-written hold/flush, saturation/clear and
// asynchronous reset sequences.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic hold_i, flush_i, clr_cnt_i;
  logic stall_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk = ~clk;

  id_ex_if #(.XLEN(XLEN)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .clr_cnt_i   (clr_cnt_i),
    .bus         (bus),
    .stall_o     (stall_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input ex_ctrl_t ctrl, input logic [31:0] pc);
    bus.id_valid_i    = v;
    bus.id_ctrl_i     = ctrl;
    bus.id_opcode_i   = opc;
    bus.id_fun3_i     = 3'b010;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_rd_i       = rd;
    bus.id_pc_i       = pc;
    bus.id_rs1_data_i = pc + 32'd1;
    bus.id_rs2_data_i = pc + 32'd2;
    bus.id_imm_i      = pc + 32'd3;
  endtask

  function automatic ex_ctrl_t mk_ctrl(input logic ld, input logic st, input logic [1:0] m2r,
                                       input logic rw, input logic me, input logic opb,
                                       input logic [3:0] alu);
    ex_ctrl_t c;
    c = '0;
    c.load = ld; c.store = st; c.mem_to_reg = m2r; c.reg_write = rw;
    c.mem_en = me; c.operand_b = opb; c.alu_control = alu;
    return c;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic v; logic [6:0] opc; logic [4:0] rs1, rs2, rd; ex_ctrl_t ctrl;
    logic [31:0] pc; logic flush;
    logic e_stall; logic e_valid; logic e_bub; logic [4:0] e_rd; ex_ctrl_t e_ctrl;
    logic [31:0] e_pc; logic [3:0] e_s, e_f;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic v, input logic [6:0] opc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input ex_ctrl_t ctrl,
                         input logic [31:0] pc, input logic fl, input logic e_stall,
                         input logic e_valid, input logic e_bub, input logic [4:0] e_rd,
                         input ex_ctrl_t e_ctrl, input logic [31:0] e_pc,
                         input logic [3:0] e_s, input logic [3:0] e_f);
    vec_t t;
    t.v = v; t.opc = opc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.ctrl = ctrl;
    t.pc = pc; t.flush = fl; t.e_stall = e_stall; t.e_valid = e_valid;
    t.e_bub = e_bub; t.e_rd = e_rd; t.e_ctrl = e_ctrl; t.e_pc = e_pc;
    t.e_s = e_s; t.e_f = e_f;
    vq.push_back(t);
  endtask

  ex_ctrl_t c_add, c_lw, c_lui, c_sw, c_zero;

  initial begin
    c_add  = mk_ctrl(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, ALU_ADD);
    c_lw   = mk_ctrl(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, ALU_ADD);
    c_lui  = mk_ctrl(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, ALU_PASS);
    c_sw   = mk_ctrl(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, ALU_ADD);
    c_zero = '0;

    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, c_zero, 32'd0);
    tick(); tick();
    chk("rst_ex_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("rst_stall",    {31'd0, stall_o},        32'd0);
    chk("rst_scnt",     {28'd0, stall_cnt_o},    32'd0);
    chk("rst_fcnt",     {28'd0, flush_cnt_o},    32'd0);
    rst_n = 1'b1;
    tick();

    //       v   opc         rs1  rs2  rd   ctrl    pc        fl   stl  val  bub  e_rd e_ctrl  e_pc     s  f
    add_vec(1, OPC_R,      1,   2,   3,   c_add,  32'h100,  0,   0,   1,   0,   3,   c_add,  32'h100, 0, 0);
    add_vec(1, OPC_LOAD,   1,   0,   5,   c_lw,   32'h104,  0,   0,   1,   0,   5,   c_lw,   32'h104, 0, 0);
    add_vec(1, OPC_R,      5,   2,   6,   c_add,  32'h108,  0,   1,   0,   1,   0,   c_zero, 32'h0,   1, 0);
    add_vec(1, OPC_R,      5,   2,   6,   c_add,  32'h108,  0,   0,   1,   0,   6,   c_add,  32'h108, 1, 0);
    add_vec(1, OPC_LOAD,   1,   0,   0,   c_lw,   32'h10c,  0,   0,   1,   0,   0,   c_lw,   32'h10c, 1, 0);
    add_vec(1, OPC_R,      0,   2,   6,   c_add,  32'h110,  0,   0,   1,   0,   6,   c_add,  32'h110, 1, 0);
    add_vec(1, OPC_LOAD,   1,   0,   5,   c_lw,   32'h114,  0,   0,   1,   0,   5,   c_lw,   32'h114, 1, 0);
    add_vec(1, OPC_LUI,    5,   5,   5,   c_lui,  32'h118,  0,   0,   1,   0,   5,   c_lui,  32'h118, 1, 0);
    add_vec(1, OPC_LOAD,   1,   0,   7,   c_lw,   32'h11c,  0,   0,   1,   0,   7,   c_lw,   32'h11c, 1, 0);
    add_vec(1, OPC_R,      7,   7,   8,   c_add,  32'h120,  1,   0,   0,   1,   0,   c_zero, 32'h0,   1, 1);
    add_vec(1, OPC_R,      7,   7,   8,   c_add,  32'h120,  0,   0,   1,   0,   8,   c_add,  32'h120, 1, 1);
    add_vec(0, OPC_R,      1,   2,   9,   c_add,  32'h124,  0,   0,   0,   0,   9,   c_zero, 32'h124, 1, 1);
    add_vec(1, OPC_LOAD,   1,   0,   10,  c_lw,   32'h128,  0,   0,   1,   0,   10,  c_lw,   32'h128, 1, 1);
    add_vec(1, OPC_STORE,  1,   10,  0,   c_sw,   32'h12c,  0,   1,   0,   1,   0,   c_zero, 32'h0,   2, 1);
    add_vec(1, OPC_STORE,  1,   10,  0,   c_sw,   32'h12c,  0,   0,   1,   0,   0,   c_sw,   32'h12c, 2, 1);

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].opc, vq[i].rs1, vq[i].rs2, vq[i].rd, vq[i].ctrl, vq[i].pc);
      flush_i = vq[i].flush;
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vq[i].e_stall});
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, bus.ex_valid_o}, {31'd0, vq[i].e_valid});
      chk($sformatf("v%0d_ctrl", i),  {17'd0, bus.ex_ctrl_o},  {17'd0, vq[i].e_ctrl});
      chk($sformatf("v%0d_rd", i),    {27'd0, bus.ex_rd_o},    {27'd0, vq[i].e_rd});
      chk($sformatf("v%0d_pc", i),    bus.ex_pc_o,             vq[i].e_pc);
      chk($sformatf("v%0d_rs1d", i),  bus.ex_rs1_data_o,       vq[i].e_bub ? 32'd0 : vq[i].e_pc + 32'd1);
      chk($sformatf("v%0d_rs2d", i),  bus.ex_rs2_data_o,       vq[i].e_bub ? 32'd0 : vq[i].e_pc + 32'd2);
      chk($sformatf("v%0d_imm", i),   bus.ex_imm_o,            vq[i].e_bub ? 32'd0 : vq[i].e_pc + 32'd3);
      chk($sformatf("v%0d_fun3", i),  {29'd0, bus.ex_fun3_o},  vq[i].e_bub ? 32'd0 : 32'd2);
      chk($sformatf("v%0d_scnt", i),  {28'd0, stall_cnt_o},    {28'd0, vq[i].e_s});
      chk($sformatf("v%0d_fcnt", i),  {28'd0, flush_cnt_o},    {28'd0, vq[i].e_f});
    end
    flush_i = 1'b0;

    // ---- flush pulsed under hold, hold released after three edges ----
    drive(1'b1, OPC_R, 5'd1, 5'd2, 5'd12, c_add, 32'h200);
    hold_i = 1'b1; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("hold1_pc",    bus.ex_pc_o, 32'h12c);
    chk("hold1_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("hold1_fcnt",  {28'd0, flush_cnt_o}, 32'd1);
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    chk("hold2_pc",   bus.ex_pc_o, 32'h12c);
    chk("hold2_scnt", {28'd0, stall_cnt_o}, 32'd2);
    chk("hold2_fcnt", {28'd0, flush_cnt_o}, 32'd1);
    tick();
    chk("hold3_pc",   bus.ex_pc_o, 32'h12c);
    chk("hold3_ctrl", {17'd0, bus.ex_ctrl_o}, {17'd0, c_sw});
    hold_i = 1'b0;
    #1;
    chk("pend_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("pend_bub_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("pend_bub_pc",    bus.ex_pc_o, 32'd0);
    chk("pend_fcnt",      {28'd0, flush_cnt_o}, 32'd2);
    tick();
    chk("after_pend_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("after_pend_pc",    bus.ex_pc_o, 32'h200);
    chk("after_pend_fcnt",  {28'd0, flush_cnt_o}, 32'd2);

    // ---- stall counter saturation (CNT_W=4) ----
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, OPC_LOAD, 5'd1, 5'd0, 5'd5, c_lw, 32'h300);
      tick();
      drive(1'b1, OPC_R, 5'd5, 5'd2, 5'd6, c_add, 32'h304);
      #1;
      chk($sformatf("sat%0d_stall", k), {31'd0, stall_o}, 32'd1);
      tick();
      tick();
      if (k == 12) chk("sat_reach15", {28'd0, stall_cnt_o}, 32'd15);
    end
    chk("sat_hold15", {28'd0, stall_cnt_o}, 32'd15);

    // ---- clear together with a stall ----
    drive(1'b1, OPC_LOAD, 5'd1, 5'd0, 5'd5, c_lw, 32'h308);
    tick();
    drive(1'b1, OPC_R, 5'd5, 5'd2, 5'd6, c_add, 32'h30c);
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    chk("clr_scnt",  {28'd0, stall_cnt_o}, 32'd0);
    chk("clr_fcnt",  {28'd0, flush_cnt_o}, 32'd0);
    chk("clr_bub",   {31'd0, bus.ex_valid_o}, 32'd0);

    // ---- asynchronous reset mid-stream ----
    drive(1'b1, OPC_R, 5'd1, 5'd2, 5'd3, c_add, 32'h400);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("pre_rst_fcnt",  {28'd0, flush_cnt_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("arst_ctrl",  {17'd0, bus.ex_ctrl_o}, 32'd0);
    chk("arst_pc",    bus.ex_pc_o, 32'd0);
    chk("arst_rd",    {27'd0, bus.ex_rd_o}, 32'd0);
    chk("arst_fcnt",  {28'd0, flush_cnt_o}, 32'd0);
    chk("arst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
